// File: rtl/serial_paralelo_sync.sv
// rtl/serial_paralelo_sync.sv - comma-aligned serial-to-parallel receiver for the phy lane
module serial_paralelo_sync #(
  parameter logic [7:0]  COMMA    = 8'hBC,
  parameter int unsigned BC_COUNT = 4
) (
  input  logic       clk_8f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic       byte_strobe
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [2:0] BC_TARGET = 3'(BC_COUNT);

  state_t     state_q, state_d;
  logic [7:0] sr_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] bc_cnt_q, bc_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       active_q, active_d;
  logic       strobe_q, strobe_d;

  // Candidate byte including the bit being sampled on this edge.
  logic [7:0] win;
  logic       is_comma;
  logic       boundary;

  assign win      = {sr_q[6:0], data_in};
  assign is_comma = (win == COMMA);
  assign boundary = (bit_cnt_q == 3'd7);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + 3'd1;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    active_d  = active_q;
    strobe_d  = 1'b0;
    unique case (state_q)
      ST_SEARCH: begin
        bit_cnt_d = bit_cnt_q;
        if (is_comma) begin
          bit_cnt_d = 3'd0;
          bc_cnt_d  = 3'd1;
          if (BC_TARGET == 3'd1) begin
            state_d  = ST_ACTIVE;
            active_d = 1'b1;
          end else begin
            state_d = ST_ALIGN;
          end
        end
      end
      ST_ALIGN: begin
        if (boundary) begin
          strobe_d = 1'b1;
          if (is_comma) begin
            bc_cnt_d = bc_cnt_q + 3'd1;
            if (bc_cnt_q + 3'd1 == BC_TARGET) begin
              state_d  = ST_ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            state_d  = ST_SEARCH;
            bc_cnt_d = 3'd0;
          end
        end
      end
      ST_ACTIVE: begin
        // Commas after training are idle fill: drop valid, keep last data.
        if (boundary) begin
          strobe_d = 1'b1;
          if (is_comma) begin
            valid_d = 1'b0;
          end else begin
            data_d  = win;
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk_8f) begin
    if (!reset_L) begin
      state_q   <= ST_SEARCH;
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= 3'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= win;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
      strobe_q  <= strobe_d;
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign active      = active_q;
  assign byte_strobe = strobe_q;

endmodule

// File: tb/tb_serial_paralelo_sync.sv
// tb/tb_serial_paralelo_sync.sv - bench for serial_paralelo_sync against a bit-history model
module tb_serial_paralelo_sync;

  localparam logic [7:0] BC  = 8'hBC;
  localparam int         BCN = 4;

  logic       clk_8f = 1'b0;
  logic       reset_L = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       byte_strobe;

  int checks = 0;
  int failures = 0;

  serial_paralelo_sync dut (
    .clk_8f     (clk_8f),
    .reset_L    (reset_L),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .active     (active),
    .byte_strobe(byte_strobe)
  );

  always #5 clk_8f = ~clk_8f;

  // Model: every bit since reset is kept; byte boundaries are every 8th
  // bit counted from the edge on which the first comma was spotted.
  bit         hist[$];
  bit         m_sync;
  int         m_anchor;
  int         m_commas;
  logic       m_active;
  logic [7:0] m_dout;
  logic       m_valid;
  logic       m_strobe;
  bit         seen_aa;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit b, input bit rst_n);
    int         n;
    logic [7:0] w;
    if (!rst_n) begin
      hist.delete();
      m_sync   = 1'b0;
      m_anchor = 0;
      m_commas = 0;
      m_active = 1'b0;
      m_dout   = 8'h00;
      m_valid  = 1'b0;
      m_strobe = 1'b0;
      return;
    end
    hist.push_back(b);
    n = hist.size() - 1;
    w = 8'h00;
    for (int k = 7; k >= 0; k--) w = {w[6:0], (n - k >= 0) ? hist[n - k] : 1'b0};
    m_strobe = 1'b0;
    if (!m_sync) begin
      if (w == BC) begin
        m_sync   = 1'b1;
        m_anchor = n;
        m_commas = 1;
        if (BCN == 1) m_active = 1'b1;
      end
    end else if (((n - m_anchor) % 8) == 0) begin
      m_strobe = 1'b1;
      if (m_active) begin
        if (w != BC) begin
          m_dout  = w;
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end else if (w == BC) begin
        m_commas++;
        if (m_commas == BCN) m_active = 1'b1;
      end else begin
        m_sync   = 1'b0;
        m_commas = 0;
      end
    end
  endtask

  task automatic send_bit(input bit b, input bit rst_n);
    @(negedge clk_8f);
    data_in = b;
    reset_L = rst_n;
    @(posedge clk_8f);
    model_step(b, rst_n);
    #1;
    if (data_out === 8'hAA) seen_aa = 1'b1;
    check("data_out", data_out, m_dout);
    check("valid_out", {7'd0, valid_out}, {7'd0, m_valid});
    check("active", {7'd0, active}, {7'd0, m_active});
    check("byte_strobe", {7'd0, byte_strobe}, {7'd0, m_strobe});
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i], 1'b1);
  endtask

  task automatic do_reset(input int edges);
    for (int i = 0; i < edges; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic train(input int n);
    for (int i = 0; i < n; i++) send_byte(BC);
  endtask

  initial begin
    logic [7:0] rb;
    int         nj;

    // Reset with random bits on the line, then training and data.
    do_reset(4);
    check("reset_data", data_out, 8'h00);
    check("reset_active", {7'd0, active}, 8'h00);
    train(3);
    check("pre_train_active", {7'd0, active}, 8'h00);
    train(1);
    check("train_active", {7'd0, active}, 8'h01);
    check("train_valid", {7'd0, valid_out}, 8'h00);
    send_byte(8'hDD);
    check("dd_data", data_out, 8'hDD);
    send_byte(8'hEE);
    check("ee_data", data_out, 8'hEE);
    send_byte(8'hFF);
    check("ff_data", data_out, 8'hFF);
    check("ff_valid", {7'd0, valid_out}, 8'h01);

    // Interrupted training.
    do_reset(1);
    seen_aa = 1'b0;
    train(3);
    send_byte(8'hAA);
    check("aa_active", {7'd0, active}, 8'h00);
    train(4);
    check("retrain_active", {7'd0, active}, 8'h01);
    send_byte(8'h11);
    check("d11_data", data_out, 8'h11);
    check("d11_valid", {7'd0, valid_out}, 8'h01);
    check("aa_never", {7'd0, seen_aa}, 8'h00);

    // Bit slip then idle in ACTIVE.
    do_reset(2);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    train(4);
    send_byte(8'h22);
    check("slip_data", data_out, 8'h22);
    check("slip_valid", {7'd0, valid_out}, 8'h01);
    send_byte(8'hCC);
    check("cc_data", data_out, 8'hCC);
    send_byte(BC);
    check("idle_valid", {7'd0, valid_out}, 8'h00);
    check("idle_data", data_out, 8'hCC);
    send_byte(8'hBB);
    check("bb_data", data_out, 8'hBB);
    check("bb_valid", {7'd0, valid_out}, 8'h01);

    // Reset at bit 3 of a byte in ACTIVE; data before new commas is ignored.
    for (int i = 7; i >= 5; i--) send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    check("mid_rst_data", data_out, 8'h00);
    check("mid_rst_active", {7'd0, active}, 8'h00);
    send_byte(8'h55);
    send_byte(8'h66);
    check("post_rst_valid", {7'd0, valid_out}, 8'h00);
    train(4);
    send_byte(8'h77);
    check("post_rst_data", data_out, 8'h77);

    // Randomized: random slip, training, random bytes (commas included).
    for (int t = 0; t < 6; t++) begin
      do_reset(1 + $urandom_range(0, 2));
      nj = $urandom_range(0, 7);
      for (int j = 0; j < nj; j++) send_bit(1'($urandom_range(0, 1)), 1'b1);
      train(4);
      for (int j = 0; j < 12; j++) begin
        rb = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 5) == 0) rb = BC;
        send_byte(rb);
      end
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j < 4; j++) send_bit(1'($urandom_range(0, 1)), 1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
